score_bcd_engine: RTL
=====================

SCORE_BCD_ENGINE -- requirements
Module: score_bcd_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 10, binary score width (4..16).
REQ-002 SHALL have parameter DIGITS, default 3, number of decimal FND digits (1..5).
REQ-003 SHALL have parameter LZ_BLANK, default 1; 1 blanks leading zeros.
REQ-004 i_Clk  in  1  single system clock; all state on rising edge.
REQ-005 i_Rst  in  1  reset, synchronous, active-low.
REQ-006 i_Add  in  1  one-cycle pulse: add i_Delta to score.
REQ-007 i_Delta  in  WIDTH  unsigned increment, sampled when i_Add=1.
REQ-008 i_Clr  in  1  one-cycle pulse: clear score to 0.
REQ-009 o_Score  out  WIDTH  current binary score.
REQ-010 o_FND  out  DIGITS*7  segment patterns; digit k at bits [7k+6:7k], k=0 least significant.
REQ-011 o_Busy  out  1  conversion in progress.
REQ-012 o_Valid  out  1  o_FND matches o_Score.
REQ-013 o_Sat  out  1  score held at MAX.

Function
REQ-014 Derived constant MAX SHALL equal min(2^WIDTH-1, 10^DIGITS-1).
REQ-015 On i_Add, score SHALL become min(score+i_Delta, MAX), computed WIDTH+1 bits wide; no wrap-around.
REQ-016 o_Sat SHALL be 1 exactly when registered score equals MAX.
REQ-017 i_Clr SHALL set score to 0 next cycle; i_Clr and i_Add in the same cycle: clear wins, i_Delta ignored.
REQ-018 Any score register change SHALL set a pending flag; i_Add with i_Delta=0, or a saturated add leaving score unchanged, SHALL NOT.
REQ-019 FSM states IDLE, LOAD, SHIFT, DONE; IDLE->LOAD when pending; LOAD snapshots score, clears pending, zeroes BCD accumulator; SHIFT runs exactly WIDTH shift-add-3 (double-dabble) steps, one per cycle; DONE latches digits to display register, then ->IDLE.
REQ-020 Latency from score-register update to o_FND update SHALL be WIDTH+3 cycles when FSM idle.
REQ-021 Score changes during LOAD/SHIFT/DONE SHALL NOT abort conversion; pending SHALL be re-set, and a new conversion SHALL start from IDLE the cycle after DONE.
REQ-022 o_FND SHALL hold the previous digit set until DONE; no intermediate BCD values visible.
REQ-023 o_Busy SHALL be 1 in LOAD, SHIFT, DONE; 0 in IDLE.
REQ-024 o_Valid SHALL be 1 only in IDLE with pending=0.
REQ-025 With LZ_BLANK=1, every digit above the most significant nonzero digit SHALL be driven with code 4'hF (blank); digit 0 SHALL never be blanked, so score 0 shows "0".
REQ-026 With LZ_BLANK=0 all DIGITS digits SHALL show, zeros included.
REQ-027 Digits beyond BCD capacity of WIDTH SHALL read 0 (blank when LZ_BLANK=1).

Reset
REQ-028 While i_Rst=0 at a clock edge: score=0, pending=1, FSM=IDLE, display register=all digits blank except digit 0 = 0.
REQ-029 Reset mid-conversion SHALL abandon the conversion; after release, first conversion SHALL show score 0 per REQ-020 latency.
REQ-030 Reset-state outputs: o_Score=0, o_Busy=0, o_Valid=0, o_Sat=0, o_FND=blank patterns with "0" in digit 0.

Structure
REQ-031 Shared package SHALL hold FSM state encoding, blank digit code 4'hF, and a 7-bit segment width constant.
REQ-032 Existing FND decoder SHALL be the single sub-module, instantiated DIGITS times via generate; it SHALL map 4'hF to all segments off.
REQ-033 No divider or multiplier SHALL be inferred; conversion is shift/add only.

Verification (WIDTH=10, DIGITS=3, LZ_BLANK=1)
REQ-034 Reset, then i_Add with i_Delta=123 -> o_Score=123 next cycle; 13 cycles later o_FND digits "1","2","3", o_Valid=1.
REQ-035 Score 990, i_Add with i_Delta=20 -> o_Score=999, o_Sat=1, display "999"; further i_Add with i_Delta=5 -> no conversion, o_Busy stays 0.
REQ-036 Score 7 -> digits blank, blank, "7"; i_Clr -> blank, blank, "0".
REQ-037 i_Add with i_Delta=5 at cycles 0, 4, 8 (during SHIFT) -> display never shows an intermediate value; final o_FND "15", o_Valid=1.
REQ-038 i_Add and i_Clr in the same cycle with score 50 -> o_Score=0, display "0".
REQ-039 i_Rst=0 asserted during SHIFT of score 456 -> outputs per REQ-030; after release, display "0", never "456".

Source files
------------

// File: rtl/score_bcd_engine_pkg.sv
// Shared definitions for the score/BCD display engine: FSM encoding, blank digit code,
// segment width and the saturation-limit helper used at elaboration time.
package score_bcd_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         SEG_W      = 7;

    // min(2^width-1, 10^digits-1); powers of ten built from shifts only
    function automatic int max_score(input int width, input int digits);
        int pow10;
        int bin_lim;
        pow10 = 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = (pow10 << 3) + (pow10 << 1);
        end
        bin_lim = (1 << width) - 1;
        return (bin_lim < (pow10 - 1)) ? bin_lim : (pow10 - 1);
    endfunction

endpackage

// File: rtl/score_bcd_engine_fnd.sv
// Seven-segment decoder for one digit (active-high, bit0 = segment a); combinational.
// Codes other than 0-9, including the blank code, turn every segment off.
module score_bcd_engine_fnd
    import score_bcd_engine_pkg::*;
(
    input  logic [3:0]       code,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = '0;
        case (code)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/score_bcd_engine.sv
// Saturating score counter with a serial double-dabble converter driving FND digits.
// Display refreshes WIDTH+3 cycles after a score change; no backpressure, late changes re-queue.
module score_bcd_engine
    import score_bcd_engine_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int DIGITS   = 3,
    parameter int LZ_BLANK = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Add,
    input  logic [WIDTH-1:0]        i_Delta,
    input  logic                    i_Clr,
    output logic [WIDTH-1:0]        o_Score,
    output logic [DIGITS*SEG_W-1:0] o_FND,
    output logic                    o_Busy,
    output logic                    o_Valid,
    output logic                    o_Sat
);

    localparam int               BCD_W     = 4 * DIGITS;
    localparam int               CNT_W     = 5;
    localparam logic [WIDTH-1:0] MAX       = WIDTH'(max_score(WIDTH, DIGITS));
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    // every digit blank except digit 0, which shows zero
    localparam logic [BCD_W-1:0] DISP_RST  = ~(BCD_W'(BLANK_CODE));

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   score;
    logic [WIDTH-1:0]   score_nxt;
    logic [WIDTH:0]     sum;
    logic               changed;
    logic               pending;
    logic [WIDTH-1:0]   bin_sr;
    logic [WIDTH-1:0]   bin_step;
    logic [BCD_W-1:0]   bcd_sr;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_step;
    logic [CNT_W-1:0]   step_cnt;
    logic [BCD_W-1:0]   disp;
    logic [BCD_W-1:0]   disp_nxt;
    logic               seen_nz;

    // score update: clear dominates, add saturates at MAX without wrapping
    always_comb begin
        sum       = {1'b0, score} + {1'b0, i_Delta};
        score_nxt = score;
        if (i_Clr) begin
            score_nxt = '0;
        end else if (i_Add) begin
            score_nxt = (sum > {1'b0, MAX}) ? MAX : sum[WIDTH-1:0];
        end
        changed = (score_nxt != score);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            score   <= '0;
            pending <= 1'b1;
        end else begin
            score <= score_nxt;
            if (changed) begin
                pending <= 1'b1;
            end else if (state == ST_LOAD) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_Busy    = 1'b1;
        case (state)
            ST_IDLE: begin
                o_Busy = 1'b0;
                if (pending) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (step_cnt == LAST_STEP) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // one double-dabble step: add 3 to any digit >= 5, then shift the pair left
    always_comb begin
        bcd_adj = bcd_sr;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sr[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
            end
        end
        bcd_step = {bcd_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
        bin_step = {bin_sr[WIDTH-2:0], 1'b0};
    end

    // leading-zero blanking scans from the top digit; digit 0 always shows
    always_comb begin
        seen_nz  = 1'b0;
        disp_nxt = bcd_sr;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd_sr[4*k +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            if ((LZ_BLANK != 0) && !seen_nz && (k != 0)) begin
                disp_nxt[4*k +: 4] = BLANK_CODE;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            bin_sr   <= '0;
            bcd_sr   <= '0;
            step_cnt <= '0;
            disp     <= DISP_RST;
        end else begin
            case (state)
                ST_LOAD: begin
                    bin_sr   <= score;
                    bcd_sr   <= '0;
                    step_cnt <= '0;
                end
                ST_SHIFT: begin
                    bin_sr   <= bin_step;
                    bcd_sr   <= bcd_step;
                    step_cnt <= step_cnt + CNT_W'(1);
                end
                ST_DONE: disp <= disp_nxt;
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_fnd
        score_bcd_engine_fnd u_fnd (
            .code (disp[4*k +: 4]),
            .seg  (o_FND[SEG_W*k +: SEG_W])
        );
    end

    assign o_Score = score;
    assign o_Sat   = (score == MAX);
    assign o_Valid = (state == ST_IDLE) && !pending;

endmodule
